mem_align_sequencer: RTL and testbench

MEM_ALIGN_SEQUENCER -- requirements
Module: mem_align_sequencer

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_load_merge.sv | 29 ++
 rtl/mem_align_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_mem_align_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 codes, sequencer state and access-size helpers
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LD_HI   = 2'd1,
        S_ST_BYTE = 2'd2
    } seq_state_t;

    // Unsupported codes count as single bytes so they are never split.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3)
            F3_W:        return 3'd4;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3)
            F3_W:        return offset != 2'd0;
            F3_H, F3_HU: return offset == 2'd3;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_merge.sv
// rtl/mem_load_merge.sv - selects and extends load bytes from a {hi, lo} word pair
module mem_load_merge
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] lo,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] result
);

    logic [2*DATA_W-1:0] pair;
    logic [DATA_W-1:0]   shifted;

    always_comb begin
        pair    = {hi, lo};
        shifted = DATA_W'(pair >> {offset, 3'b000});
        case (funct3)
            F3_B:    result = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            F3_H:    result = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_align_sequencer.sv
// rtl/mem_align_sequencer.sv - splits misaligned loads/stores into aligned memory ops; MEM_MISALIGN_TRAP_EN traps instead
module mem_align_sequencer
    import mem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_trap
`endif
);

    seq_state_t            state, next_state;
    logic [1:0]            counter, next_counter;
    logic [DATA_W-1:0]     lo_word;
    logic [DM_ADDRESS-1:0] cap_addr;
    logic [DATA_W-1:0]     cap_wdata;
    logic [2:0]            cap_funct3;

    logic                  req_mis;
    logic                  load_lo, capture;
    logic [1:0]            byte_k;
    logic                  o_stall, o_resp, o_read, o_write;
    logic [DM_ADDRESS-1:0] o_a;
    logic [DATA_W-1:0]     o_wd;
    logic [2:0]            o_f3;

    logic [DATA_W-1:0]     m_hi, m_lo, merged;
    logic [1:0]            m_off;
    logic [2:0]            m_f3;

    assign req_mis = req_valid && (req_read || req_write)
                     && is_misaligned(req_funct3, req_addr[1:0]);

    // counter holds the bytes still to be written, so the byte index is size - counter
    assign byte_k = 2'(access_size(cap_funct3) - {1'b0, counter});

    always_comb begin
        next_state   = state;
        next_counter = counter;
        load_lo      = 1'b0;
        capture      = 1'b0;
        o_stall      = 1'b0;
        o_resp       = 1'b0;
        o_read       = 1'b0;
        o_write      = 1'b0;
        o_a          = '0;
        o_wd         = '0;
        o_f3         = '0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (!req_mis) begin
                        o_read  = req_read;
                        o_write = req_write;
                        o_a     = req_addr;
                        o_wd    = req_wdata;
                        o_f3    = req_funct3;
                        o_resp  = req_read;
                    end
`ifndef MEM_MISALIGN_TRAP_EN
                    else if (req_read) begin
                        o_read     = 1'b1;
                        o_a        = {req_addr[DM_ADDRESS-1:2], 2'b00};
                        o_f3       = F3_W;
                        o_stall    = 1'b1;
                        load_lo    = 1'b1;
                        capture    = 1'b1;
                        next_state = S_LD_HI;
                    end else begin
                        o_write      = 1'b1;
                        o_a          = req_addr;
                        o_wd         = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
                        o_f3         = F3_B;
                        o_stall      = 1'b1;
                        capture      = 1'b1;
                        next_counter = 2'(access_size(req_funct3) - 3'd1);
                        next_state   = S_ST_BYTE;
                    end
`endif
                end
            end
            S_LD_HI: begin
                o_read     = 1'b1;
                o_a        = {cap_addr[DM_ADDRESS-1:2], 2'b00} + DM_ADDRESS'(4);
                o_f3       = F3_W;
                o_resp     = 1'b1;
                next_state = S_IDLE;
            end
            S_ST_BYTE: begin
                o_write      = 1'b1;
                o_a          = cap_addr + DM_ADDRESS'(byte_k);
                o_wd         = {{(DATA_W-8){1'b0}}, cap_wdata[{byte_k, 3'b000} +: 8]};
                o_f3         = F3_B;
                o_stall      = counter > 2'd1;
                next_counter = counter - 2'd1;
                if (counter <= 2'd1) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        if (state == S_LD_HI) begin
            m_hi  = rd;
            m_lo  = lo_word;
            m_off = cap_addr[1:0];
            m_f3  = cap_funct3;
        end else begin
            m_hi  = '0;
            m_lo  = rd;
            m_off = 2'd0;
            m_f3  = F3_W;
        end
    end

    mem_load_merge #(.DATA_W(DATA_W)) u_merge (
        .hi     (m_hi),
        .lo     (m_lo),
        .offset (m_off),
        .funct3 (m_f3),
        .result (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            counter    <= '0;
            lo_word    <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_funct3 <= '0;
        end else begin
            state   <= next_state;
            counter <= next_counter;
            if (load_lo) lo_word <= rd;
            if (capture) begin
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                cap_funct3 <= req_funct3;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) misalign_trap <= 1'b0;
        else        misalign_trap <= (state == S_IDLE) && req_mis;
    end
`endif

    // Outputs are forced quiet during reset so an aborted store writes nothing more.
    assign stall      = rst_n & o_stall;
    assign resp_valid = rst_n & o_resp;
    assign MemRead    = rst_n & o_read;
    assign MemWrite   = rst_n & o_write;
    assign a          = rst_n ? o_a  : '0;
    assign wd         = rst_n ? o_wd : '0;
    assign Funct3     = rst_n ? o_f3 : '0;
    assign resp_rdata = (rst_n && o_resp) ? merged : '0;

endmodule

// File: tb/tb_mem_align_sequencer.sv
// tb/tb_mem_align_sequencer.sv - self-checking bench with byte-array memory and reference model
module tb_mem_align_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_read, req_write;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        stall, resp_valid, MemRead, MemWrite;
    logic [31:0] resp_rdata, wd, rd;
    logic [8:0]  a, a_p1;
    logic [2:0]  Funct3;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_align_sequencer #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .a          (a),
        .wd         (wd),
        .Funct3     (Funct3),
        .rd         (rd)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_trap (misalign_trap)
`endif
    );

    // Data memory model: byte array, combinational read, write on rising edge
    logic [7:0]  mem [512];
    logic        mem_clr, poke_en;
    logic [8:0]  poke_a;
    logic [31:0] poke_d;

    assign a_p1 = a + 9'd1;

    always_comb begin
        rd = '0;
        case (Funct3)
            3'b000:  rd = {{24{mem[a][7]}}, mem[a]};
            3'b100:  rd = {24'h0, mem[a]};
            3'b001:  rd = {{16{mem[a_p1][7]}}, mem[a_p1], mem[a]};
            3'b101:  rd = {16'h0, mem[a_p1], mem[a]};
            default: rd = {mem[{a[8:2], 2'b11}], mem[{a[8:2], 2'b10}],
                           mem[{a[8:2], 2'b01}], mem[{a[8:2], 2'b00}]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        end else if (poke_en) begin
            for (int i = 0; i < 4; i++) mem[poke_a + 9'(i)] <= poke_d[8*i +: 8];
        end else if (MemWrite) begin
            case (Funct3)
                3'b000: mem[a] <= wd[7:0];
                3'b001: begin
                    mem[a]    <= wd[7:0];
                    mem[a_p1] <= wd[15:8];
                end
                default: for (int i = 0; i < 4; i++) mem[{a[8:2], 2'(i)}] <= wd[8*i +: 8];
            endcase
        end
    end

    // Reference model: memory as plain bytes, accesses as byte runs modulo 512
    logic [7:0] ref_mem [512];

    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b010) return 4;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 1;
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input int addr);
        int sz = acc_size(f3);
        return (sz == 4 && addr % 4 != 0) || (sz == 2 && addr % 4 == 3);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int addr);
        logic [31:0] v = '0;
        for (int i = 0; i < acc_size(f3); i++) v[8*i +: 8] = ref_mem[(addr + i) % 512];
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int addr, input logic [31:0] d);
        for (int i = 0; i < acc_size(f3); i++) ref_mem[(addr + i) % 512] = d[8*i +: 8];
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic poke(input logic [8:0] ad, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a  = ad;
        poke_d  = d;
        @(negedge clk);
        poke_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[(int'(ad) + i) % 512] = d[8*i +: 8];
    endtask

    logic [8:0] tr_a [16];
    logic [7:0] tr_b [16];
    logic       tr_s [16];
    logic       tr_w [16];

    task automatic run_req(input logic rq, input logic wq, input logic [8:0] ad,
                           input logic [31:0] wdv, input logic [2:0] f3,
                           output int ncyc, output logic [31:0] rdata, output logic got);
        logic done = 1'b0;
        ncyc  = 0;
        rdata = '0;
        got   = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_read   = rq;
        req_write  = wq;
        req_addr   = ad;
        req_wdata  = wdv;
        req_funct3 = f3;
        for (int c = 0; c < 12; c++) begin
            #1;
            tr_a[c] = a;
            tr_b[c] = wd[7:0];
            tr_s[c] = stall;
            tr_w[c] = MemWrite;
            ncyc    = c + 1;
            if (resp_valid) begin
                got   = 1'b1;
                rdata = resp_rdata;
            end
            if (!stall) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("request_completes", {63'd0, done}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    typedef struct {
        logic        poke_en;
        logic [8:0]  poke_a;
        logic [31:0] poke_d;
        logic [2:0]  f3;
        logic [8:0]  addr;
        int          cyc;
        logic [31:0] rdata;
        logic        chk_a;
        logic [8:0]  a0;
        logic [8:0]  a1;
    } vec_t;

    vec_t        tbl [10];
    int          ncyc;
    logic [31:0] rdata;
    logic        got;

    initial begin
        rst_n = 1'b0;
        mem_clr = 1'b1;
        poke_en = 1'b0;
        poke_a = '0;
        poke_d = '0;
        req_valid = 1'b1;
        req_read = 1'b1;
        req_write = 1'b0;
        req_addr = 9'h013;
        req_wdata = 32'h12345678;
        req_funct3 = 3'b010;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;

        @(negedge clk);
        #1;
        check("reset_outputs", {stall, resp_valid, MemRead, MemWrite, a, wd, Funct3, resp_rdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_clr = 1'b0;
        req_valid = 1'b0;
        req_read = 1'b0;
        #1;
        check("idle_outputs", {stall, resp_valid, MemRead, MemWrite, a, wd, Funct3}, 64'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        poke(9'h010, 32'hDEADBEEF);
        @(negedge clk);
        req_valid = 1'b1;
        req_read = 1'b1;
        req_addr = 9'h002;
        req_funct3 = 3'b010;
        #1;
        check("trap_no_read", {62'd0, MemRead, stall}, 64'd0);
        check("trap_not_yet", {63'd0, misalign_trap}, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        req_read = 1'b0;
        #1;
        check("trap_pulse", {63'd0, misalign_trap}, 64'd1);
        @(negedge clk);
        #1;
        check("trap_one_cycle", {63'd0, misalign_trap}, 64'd0);
        run_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, ncyc, rdata, got);
        check("trap_aligned_lw", {rdata, 31'd0, got}, {32'hDEADBEEF, 32'd1});
`else
        poke(9'h014, 32'h88776655);
        poke(9'h1FC, 32'h80FFFFFF);
        poke(9'h000, 32'h000000FF);

        tbl[0] = '{1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 9'h010, 1, 32'hDEADBEEF, 1'b1, 9'h010, 9'h000};
        tbl[1] = '{1'b1, 9'h010, 32'h44332211, 3'b010, 9'h013, 2, 32'h77665544, 1'b1, 9'h010, 9'h014};
        tbl[2] = '{1'b0, 9'h000, 32'h0,        3'b001, 9'h1FF, 2, 32'hFFFFFF80, 1'b1, 9'h1FC, 9'h000};
        tbl[3] = '{1'b0, 9'h000, 32'h0,        3'b101, 9'h1FF, 2, 32'h0000FF80, 1'b1, 9'h1FC, 9'h000};
        tbl[4] = '{1'b0, 9'h000, 32'h0,        3'b000, 9'h013, 1, 32'h00000044, 1'b0, 9'h000, 9'h000};
        tbl[5] = '{1'b0, 9'h000, 32'h0,        3'b001, 9'h012, 1, 32'h00004433, 1'b0, 9'h000, 9'h000};
        tbl[6] = '{1'b0, 9'h000, 32'h0,        3'b010, 9'h012, 2, 32'h66554433, 1'b1, 9'h010, 9'h014};
        tbl[7] = '{1'b0, 9'h000, 32'h0,        3'b101, 9'h011, 1, 32'h00003322, 1'b0, 9'h000, 9'h000};
        tbl[8] = '{1'b0, 9'h000, 32'h0,        3'b000, 9'h1FF, 1, 32'hFFFFFF80, 1'b0, 9'h000, 9'h000};
        tbl[9] = '{1'b0, 9'h000, 32'h0,        3'b011, 9'h013, 1, 32'h44332211, 1'b0, 9'h000, 9'h000};

        for (int v = 0; v < 10; v++) begin
            if (tbl[v].poke_en) poke(tbl[v].poke_a, tbl[v].poke_d);
            run_req(1'b1, 1'b0, tbl[v].addr, 32'h0, tbl[v].f3, ncyc, rdata, got);
            check($sformatf("vec%0d_cycles", v), 64'(ncyc), 64'(tbl[v].cyc));
            check($sformatf("vec%0d_rdata", v), {rdata, 31'd0, got}, {tbl[v].rdata, 32'd1});
            if (tbl[v].chk_a) begin
                check($sformatf("vec%0d_addr0", v), 64'(tr_a[0]), 64'(tbl[v].a0));
                check($sformatf("vec%0d_addr1", v), 64'(tr_a[1]), 64'(tbl[v].a1));
            end
        end

        // Misaligned SW: four byte writes with stall 1,1,1,0
        poke(9'h020, 32'h00000011);
        run_req(1'b0, 1'b1, 9'h021, 32'hAABBCCDD, 3'b010, ncyc, rdata, got);
        ref_store(3'b010, 'h021, 32'hAABBCCDD);
        check("sw_cycles", 64'(ncyc), 64'd4);
        for (int c = 0; c < 4; c++) begin
            logic [31:0] sw_d = 32'hAABBCCDD;
            check($sformatf("sw_addr%0d", c), 64'(tr_a[c]), 64'(9'h021 + 9'(c)));
            check($sformatf("sw_byte%0d", c), 64'(tr_b[c]), 64'(sw_d[8*c +: 8]));
            check($sformatf("sw_stall%0d", c), {62'd0, tr_s[c], tr_w[c]}, {62'd0, c < 3, 1'b1});
        end
        run_req(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, ncyc, rdata, got);
        check("sw_readback", 64'(rdata), 64'h00000000BBCCDD11);

        // Reset during the second byte of a misaligned SW
        poke(9'h040, 32'h0);
        poke(9'h044, 32'h0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 9'h041;
        req_wdata = 32'h11223344;
        req_funct3 = 3'b010;
        #1;
        check("rst_seq_first", {54'd0, stall, a}, {54'd0, 1'b1, 9'h041});
        @(negedge clk);
        #1;
        check("rst_seq_second", {54'd0, stall, a}, {54'd0, 1'b1, 9'h042});
        rst_n = 1'b0;
        #1;
        check("rst_seq_quiet", {62'd0, MemWrite, stall}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        #1;
        check("rst_seq_idle", {62'd0, MemWrite, stall}, 64'd0);
        ref_mem['h041] = 8'h44;
        run_req(1'b1, 1'b0, 9'h040, 32'h0, 3'b010, ncyc, rdata, got);
        check("rst_seq_word", {rdata, 32'(ncyc)}, {32'h00004400, 32'd1});

        // Randomized traffic against the reference model
        for (int t = 0; t < 300; t++) begin
            logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};
            logic        is_ld = 1'($urandom_range(0, 1));
            int          ad    = $urandom_range(0, 511);
            logic [31:0] d     = $urandom;
            logic [2:0]  f3    = is_ld ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
            int          exp_c = ref_mis(f3, ad) ? (is_ld ? 2 : acc_size(f3)) : 1;
            logic [31:0] exp_d = ref_load(f3, ad);
            run_req(is_ld, !is_ld, 9'(ad), d, f3, ncyc, rdata, got);
            check($sformatf("rnd%0d_cycles f3=%0d addr=%0h", t, f3, ad), 64'(ncyc), 64'(exp_c));
            if (is_ld) check($sformatf("rnd%0d_load f3=%0d addr=%0h", t, f3, ad), {rdata, 31'd0, got}, {exp_d, 32'd1});
            else begin
                check($sformatf("rnd%0d_store_noresp", t), {63'd0, got}, 64'd0);
                ref_store(f3, ad, d);
            end
        end

        @(negedge clk);
        for (int w = 0; w < 128; w++)
            check($sformatf("mem_word_%0h", 4*w),
                  {32'd0, mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]},
                  {32'd0, ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
